lcd_mode_sequencer: RTL

- Dot-level timing controller for the Gameboy video path.
- Counts dots and lines, generates the PPU mode code (00 h-blank, 01 v-blank, 10 OAM, 11 OAM+VRAM) consumed by the LCD scan-doubler, the pixel-push strobe that writes the scanline buffer, and the LY register.
- Raises the v-blank and STAT interrupts.
- Sits between the CPU register file (LCDC/STAT/LYC) and the pixel fetcher/LCD output stage.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_mode_sequencer_if.sv | 30 +++
 rtl/lcd_stat_irq.sv | 37 +++
 rtl/lcd_mode_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared encodings and timing constants for the LCD dot/line sequencer.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'b00,
        MODE_VBLANK = 2'b01,
        MODE_OAM    = 2'b10,
        MODE_XFER   = 2'b11
    } lcd_mode_e;

    localparam int DOTS_PER_LINE = 456;
    localparam int LINES         = 154;
    localparam int VIS_LINES     = 144;
    localparam int OAM_DOTS      = 80;
    localparam int H_PIXELS      = 160;
    localparam int FETCH_LEAD    = 12;
    localparam int LEAD_W        = $clog2(FETCH_LEAD + 1);

    localparam int STAT_IE_HBLANK = 0;
    localparam int STAT_IE_VBLANK = 1;
    localparam int STAT_IE_OAM    = 2;
    localparam int STAT_IE_LYC    = 3;

endpackage

// File: rtl/lcd_mode_sequencer_if.sv
// Bundle between the register file / pixel fetcher and the mode sequencer.
interface lcd_mode_sequencer_if;
    import lcd_pkg::*;

    logic       ce;
    logic       lcd_on;
    logic       pix_ready;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    lcd_mode_e  mode;
    logic [7:0] ly;
    logic [7:0] lx;
    logic [8:0] dot;
    logic       pix_push;
    logic       fetch_start;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;

    modport master (
        output ce, lcd_on, pix_ready, lyc, stat_ie,
        input  mode, ly, lx, dot, pix_push, fetch_start, lyc_match, vblank_irq, stat_irq
    );

    modport slave (
        input  ce, lcd_on, pix_ready, lyc, stat_ie,
        output mode, ly, lx, dot, pix_push, fetch_start, lyc_match, vblank_irq, stat_irq
    );

endinterface

// File: rtl/lcd_stat_irq.sv
// STAT interrupt line: OR of enabled sources, registered, with a pulse on its rising edge only.
module lcd_stat_irq
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  lcd_mode_e  mode,
    input  logic       lyc_match,
    input  logic [3:0] stat_ie,
    output logic       stat_irq
);

    logic line_d, line_q;
    logic stat_irq_d, stat_irq_q;

    always_comb begin
        line_d = active && ((stat_ie[STAT_IE_HBLANK] && (mode == MODE_HBLANK)) ||
                            (stat_ie[STAT_IE_VBLANK] && (mode == MODE_VBLANK)) ||
                            (stat_ie[STAT_IE_OAM]    && (mode == MODE_OAM))    ||
                            (stat_ie[STAT_IE_LYC]    && lyc_match));
        stat_irq_d = line_d && !line_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q     <= 1'b0;
            stat_irq_q <= 1'b0;
        end else begin
            line_q     <= line_d;
            stat_irq_q <= stat_irq_d;
        end
    end

    assign stat_irq = stat_irq_q;

endmodule

// File: rtl/lcd_mode_sequencer.sv
// Dot/line timing controller: PPU mode, LY, pixel-push strobe and LCD interrupts.
module lcd_mode_sequencer
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    lcd_mode_sequencer_if.slave  bus
);

    lcd_mode_e        mode_d, mode_q;
    logic             running_d, running_q;
    logic [8:0]       dot_d, dot_q;
    logic [7:0]       ly_d, ly_q;
    logic [7:0]       lx_d, lx_q;
    logic [LEAD_W-1:0] lead_d, lead_q;
    logic             fetch_start_d, fetch_start_q;
    logic             vblank_irq_d, vblank_irq_q;
    logic             lyc_match_d, lyc_match_q;
    logic             pix_push;
    logic             last_dot;

    always_comb begin
        mode_d        = mode_q;
        running_d     = running_q;
        dot_d         = dot_q;
        ly_d          = ly_q;
        lx_d          = lx_q;
        lead_d        = lead_q;
        fetch_start_d = 1'b0;
        vblank_irq_d  = 1'b0;
        pix_push      = 1'b0;
        last_dot      = (dot_q == 9'(DOTS_PER_LINE - 1));
        lyc_match_d   = bus.lcd_on && (ly_q == bus.lyc);

        if (!bus.lcd_on) begin
            mode_d    = MODE_HBLANK;
            running_d = 1'b0;
            dot_d     = '0;
            ly_d      = '0;
            lx_d      = '0;
            lead_d    = '0;
        end else if (bus.ce) begin
            if (!running_q) begin
                // First dot after enable only arms line 0; counting starts on the following ce.
                running_d = 1'b1;
                mode_d    = MODE_OAM;
            end else begin
                dot_d = last_dot ? 9'd0 : dot_q + 9'd1;
                case (mode_q)
                    MODE_OAM: begin
                        if (dot_q == 9'(OAM_DOTS - 1)) begin
                            mode_d        = MODE_XFER;
                            lx_d          = '0;
                            lead_d        = '0;
                            fetch_start_d = 1'b1;
                        end
                    end
                    MODE_XFER: begin
                        if (lead_q != LEAD_W'(FETCH_LEAD)) begin
                            lead_d = lead_q + LEAD_W'(1);
                        end else if (bus.pix_ready && (lx_q < 8'(H_PIXELS))) begin
                            pix_push = 1'b1;
                            lx_d     = lx_q + 8'd1;
                            if (lx_q == 8'(H_PIXELS - 1)) begin
                                mode_d = MODE_HBLANK;
                            end
                        end
                        // A starved transfer is cut off so the final dot of the line is h-blank.
                        if (dot_q == 9'(DOTS_PER_LINE - 2)) begin
                            mode_d = MODE_HBLANK;
                        end
                    end
                    default: begin
                    end
                endcase
                if (last_dot) begin
                    ly_d         = (ly_q == 8'(LINES - 1)) ? 8'd0 : ly_q + 8'd1;
                    mode_d       = (ly_d < 8'(VIS_LINES)) ? MODE_OAM : MODE_VBLANK;
                    vblank_irq_d = (ly_d == 8'(VIS_LINES));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= MODE_HBLANK;
            running_q     <= 1'b0;
            dot_q         <= '0;
            ly_q          <= '0;
            lx_q          <= '0;
            lead_q        <= '0;
            fetch_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
            lyc_match_q   <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            running_q     <= running_d;
            dot_q         <= dot_d;
            ly_q          <= ly_d;
            lx_q          <= lx_d;
            lead_q        <= lead_d;
            fetch_start_q <= fetch_start_d;
            vblank_irq_q  <= vblank_irq_d;
            lyc_match_q   <= lyc_match_d;
        end
    end

    // STAT sources see next-state mode so a v-blank STAT edge lands with vblank_irq.
    lcd_stat_irq u_stat (
        .clk       (clk),
        .reset     (reset),
        .active    (running_d),
        .mode      (mode_d),
        .lyc_match (lyc_match_d),
        .stat_ie   (bus.stat_ie),
        .stat_irq  (bus.stat_irq)
    );

    assign bus.mode        = mode_q;
    assign bus.ly          = ly_q;
    assign bus.lx          = lx_q;
    assign bus.dot         = dot_q;
    assign bus.pix_push    = pix_push;
    assign bus.fetch_start = fetch_start_q;
    assign bus.vblank_irq  = vblank_irq_q;
    assign bus.lyc_match   = lyc_match_q;

endmodule
